lfsr_rng: RTL
=============

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 SHALL have parameter WIDTH, default 16, LFSR state width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter OUT_W, default 4, random output width; 1 <= OUT_W <= WIDTH.
REQ-003 SHALL have parameter SEED, default 32'h0000ACE1 truncated to WIDTH, reset and fallback state; must be nonzero.
REQ-004 SHALL have parameter MAX_TRIES, default 8, maximum rejection attempts per draw; must be >= 1.
REQ-005 SHALL have port CLK100MHZ  input  1  sole clock, rising edge.
REQ-006 SHALL have port CPU_RESETN  input  1  asynchronous active-low reset.
REQ-007 SHALL have port seed_load  input  1  load seed into LFSR this edge.
REQ-008 SHALL have port seed  input  WIDTH  seed value.
REQ-009 SHALL have port req  input  1  draw request, sampled only in IDLE.
REQ-010 SHALL have port limit  input  OUT_W  exclusive upper bound; 0 means full 2^OUT_W range; sampled every DRAW cycle.
REQ-011 SHALL have port rnd  output  OUT_W  last accepted random value, held until next acceptance.
REQ-012 SHALL have port rnd_valid  output  1  one-cycle pulse, rnd updated.
REQ-013 SHALL have port busy  output  1  high while in DRAW.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse coincident with rnd_valid when MAX_TRIES exhausted.
REQ-015 SHALL have port draw_cnt  output  16  accepted-draw counter (see Configuration).

Function
REQ-016 SHALL implement a Fibonacci LFSR, shifting left every clock unconditionally (free-running), new LSB = XOR of tap bits: 8:{8,6,5,4}; 16:{16,15,13,4}; 24:{24,23,22,17}; 32:{32,22,2,1} (1-based).
REQ-017 SHALL, when seed_load is high, load seed instead of shifting; seed == 0 loads SEED instead, so the all-zero lock-up state is never entered.
REQ-018 SHALL have two-state FSM IDLE/DRAW; IDLE -> DRAW on edge where req=1; req in DRAW ignored.
REQ-019 SHALL, on each DRAW edge, take candidate = LFSR state before that edge, bits [OUT_W-1:0].
REQ-020 SHALL accept if limit == 0 or candidate < limit: rnd <= candidate, rnd_valid pulse, tries cleared, -> IDLE.
REQ-021 SHALL, on rejection, increment tries; when the rejection is the MAX_TRIES-th, instead set rnd <= 0, pulse rnd_valid and timeout, -> IDLE.
REQ-022 SHALL give minimum latency 2 edges: req sampled at edge k, rnd_valid high after edge k+1; maximum MAX_TRIES+1 edges.
REQ-023 SHALL, on seed_load coincident with req in IDLE, accept both; first candidate is then the loaded seed's low bits.
REQ-024 SHALL, on seed_load during DRAW, continue drawing; subsequent candidates come from the new sequence.
REQ-025 SHALL have maximal period 2^WIDTH-1 from any nonzero state.
REQ-026 SHALL assert busy combinationally from FSM state; rnd, rnd_valid, timeout registered.

Reset
REQ-027 SHALL, on CPU_RESETN low, asynchronously set LFSR = SEED, FSM = IDLE, tries = 0, rnd = 0, rnd_valid = 0, timeout = 0, draw_cnt = 0.
REQ-028 SHALL abort any draw on reset mid-DRAW with no rnd_valid pulse; release is synchronous to CLK100MHZ.

Configuration
REQ-029 SHALL, with LFSR_RNG_STATS_EN defined, increment draw_cnt (wrapping 0xFFFF -> 0x0000) on every rnd_valid, timeouts included.
REQ-030 SHALL, without LFSR_RNG_STATS_EN, tie draw_cnt to 0 and synthesise no counter; all other behaviour identical.

Verification
REQ-031 SHALL cover: WIDTH=16 reset, no stimulus -> LFSR == 0xACE1 after release; returns to 0xACE1 after exactly 65535 edges.
REQ-032 SHALL cover: WIDTH=8, seed_load with seed=0x00 -> state == SEED[7:0]; period exactly 255 thereafter.
REQ-033 SHALL cover: limit=1, 100 draws -> every rnd == 0, timeout only when MAX_TRIES candidates nonzero; agrees with model.
REQ-034 SHALL cover: MAX_TRIES=1, seed_load=1 seed=0x0003 req=1 same edge, limit=1 -> next edge rnd_valid=1, timeout=1, rnd=0.
REQ-035 SHALL cover: limit=0, req at edge k -> rnd_valid after edge k+1, rnd == LFSR[3:0] before edge k+1; req during busy ignored.
REQ-036 SHALL cover: CPU_RESETN low mid-DRAW -> busy, rnd_valid, rnd, draw_cnt all 0 immediately; with STATS_EN, 70000 draws -> draw_cnt == 70000 mod 65536.

Source files
------------

// File: rtl/lfsr_rng.sv
// lfsr_rng: free-running Fibonacci LFSR with a rejection-sampling draw engine.
// Each request yields one value in [0, limit), or the full 2^OUT_W range when
// limit == 0. A draw gives up after MAX_TRIES rejections, returns 0 and flags
// timeout.
//
// Optional feature: define LFSR_RNG_STATS_EN to build the accepted-draw counter
// on draw_cnt. When it is not defined, draw_cnt is tied to zero.
//
// Ports:
//   CLK100MHZ  in   sole clock, rising edge
//   CPU_RESETN in   asynchronous active-low reset
//   seed_load  in   load seed into the LFSR on this edge instead of shifting
//   seed       in   [WIDTH] seed value; 0 selects the SEED parameter
//   req        in   draw request, sampled only in IDLE
//   limit      in   [OUT_W] exclusive upper bound, 0 = full range
//   rnd        out  [OUT_W] last accepted value, held until the next acceptance
//   rnd_valid  out  one-cycle pulse when rnd is updated
//   busy       out  high while a draw is in progress (decoded from FSM state)
//   timeout    out  one-cycle pulse with rnd_valid when MAX_TRIES is exhausted
//   draw_cnt   out  [16] completed-draw counter, timeouts included
module lfsr_rng #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_W     = 4,
  parameter logic [31:0] SEED      = 32'h0000ACE1,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy,
  output logic             timeout,
  output logic [15:0]      draw_cnt
);

  // Feedback tap masks (0-based bit positions) for the supported widths
  function automatic logic [31:0] tap_mask(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_D008;
    endcase
  endfunction

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  // Reject illegal parameterisations at elaboration
  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 8, 16, 24 or 32");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng: OUT_W must be in 1..WIDTH");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr_rng: SEED truncated to WIDTH must be nonzero");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng: MAX_TRIES must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   lfsr, lfsr_n;
  logic [TRY_W-1:0]   tries, tries_n;
  logic [OUT_W-1:0]   rnd_n;
  logic               rnd_valid_n;
  logic               timeout_n;
  logic [OUT_W-1:0]   cand;
  logic               fb;

  // LFSR next state; a zero seed falls back to SEED so lock-up is unreachable
  always_comb begin
    fb = ^(lfsr & TAPS);
    if (seed_load) begin
      lfsr_n = (seed == '0) ? SEED_W : seed;
    end else begin
      lfsr_n = {lfsr[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      lfsr <= SEED_W;
    end else begin
      lfsr <= lfsr_n;
    end
  end

  // Candidate is the pre-edge LFSR state, so a seed loaded with req is drawn first
  assign cand = lfsr[OUT_W-1:0];

  // Draw FSM next-state and registered-output logic
  always_comb begin
    state_n     = state;
    tries_n     = tries;
    rnd_n       = rnd;
    rnd_valid_n = 1'b0;
    timeout_n   = 1'b0;
    case (state)
      IDLE: begin
        tries_n = '0;
        if (req) begin
          state_n = DRAW;
        end
      end
      DRAW: begin
        if ((limit == '0) || (cand < limit)) begin
          rnd_n       = cand;
          rnd_valid_n = 1'b1;
          tries_n     = '0;
          state_n     = IDLE;
        end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          // This rejection is the last allowed one
          rnd_n       = '0;
          rnd_valid_n = 1'b1;
          timeout_n   = 1'b1;
          tries_n     = '0;
          state_n     = IDLE;
        end else begin
          tries_n = tries + TRY_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tries_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= IDLE;
      tries     <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      tries     <= tries_n;
      rnd       <= rnd_n;
      rnd_valid <= rnd_valid_n;
      timeout   <= timeout_n;
    end
  end

  assign busy = (state == DRAW);

`ifdef LFSR_RNG_STATS_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt;

  // Counts every completed draw; wraps naturally
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt <= '0;
    end else if (rnd_valid_n) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign draw_cnt = cnt;
`else
  assign draw_cnt = '0;
`endif

endmodule
